// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve unit and its BHT.
package branch_pkg;

    // Conditional-branch funct3 encodings; 010 and 011 are illegal.
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    // Weakly not-taken.
    localparam logic [1:0]  BHT_RESET_VAL = 2'b01;
    localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundles the IF prediction, EX resolve, redirect and statistics signals.
interface branch_resolve_unit_if;

    logic        if_is_branch_i;
    logic [31:0] if_pc_i;
    logic        if_pred_taken_o;

    logic        ex_valid_i;
    logic        ex_stall_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;

    logic        br_less_i;
    logic        br_equal_i;
    logic        br_unsigned_o;

    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;

    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    // Pipeline side: drives IF/EX/comparator inputs, consumes results.
    modport master (
        output if_is_branch_i, if_pc_i,
        output ex_valid_i, ex_stall_i, ex_funct3_i, ex_pc_i, ex_target_i, ex_pred_taken_i,
        output br_less_i, br_equal_i,
        input  if_pred_taken_o, br_unsigned_o,
        input  redirect_valid_o, redirect_pc_o, flush_o,
        input  branch_cnt_o, mispred_cnt_o
    );

    // Branch resolve unit side.
    modport slave (
        input  if_is_branch_i, if_pc_i,
        input  ex_valid_i, ex_stall_i, ex_funct3_i, ex_pc_i, ex_target_i, ex_pred_taken_i,
        input  br_less_i, br_equal_i,
        output if_pred_taken_o, br_unsigned_o,
        output redirect_valid_o, redirect_pc_o, flush_o,
        output branch_cnt_o, mispred_cnt_o
    );

endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: async read, one update port.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 64,
    localparam int unsigned IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,

    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] ctr_q [BHT_DEPTH];
    logic [1:0] ctr_d [BHT_DEPTH];

    // Read sees the registered value, so a same-cycle update is not bypassed.
    assign rd_taken_o = ctr_q[rd_idx_i][1];

    // Saturating increment on taken, decrement on not-taken.
    always_comb begin
        ctr_d = ctr_q;
        if (upd_en_i) begin
            if (upd_taken_i) begin
                if (ctr_q[upd_idx_i] != 2'b11) begin
                    ctr_d[upd_idx_i] = ctr_q[upd_idx_i] + 2'd1;
                end
            end else begin
                if (ctr_q[upd_idx_i] != 2'b00) begin
                    ctr_d[upd_idx_i] = ctr_q[upd_idx_i] - 2'd1;
                end
            end
        end
    end

    // Counter array state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctr_q <= '{default: BHT_RESET_VAL};
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: outcome decode, mispredict redirect, BHT and statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 64,
    localparam int unsigned IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    branch_resolve_unit_if.slave bus_io
);

    logic        taken;
    logic        legal;
    logic        resolve;
    logic        mispred;

    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic        bht_rd_taken;
    logic        unused_pc_bits;

    // Only the BHT index bits of the IF PC matter here.
    assign unused_pc_bits = ^{bus_io.if_pc_i[31:IDX_W+2], bus_io.if_pc_i[1:0]};

    // funct3[1] distinguishes the unsigned compares and is harmless for BEQ/BNE.
    assign bus_io.br_unsigned_o = bus_io.ex_funct3_i[1];

    // Decode funct3 and comparator flags into a taken outcome.
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        unique case (bus_io.ex_funct3_i)
            F3_BEQ:          taken = bus_io.br_equal_i;
            F3_BNE:          taken = !bus_io.br_equal_i;
            F3_BLT, F3_BLTU: taken = bus_io.br_less_i;
            F3_BGE, F3_BGEU: taken = !bus_io.br_less_i;
            default:         legal = 1'b0;
        endcase
    end

    // While a redirect is out, EX holds a wrong-path instruction and is ignored.
    assign resolve = bus_io.ex_valid_i && !bus_io.ex_stall_i && !redirect_valid_q && legal;
    assign mispred = resolve && (taken != bus_io.ex_pred_taken_i);

    // Next-state for the redirect pulse and the statistics counters.
    always_comb begin
        redirect_valid_d = mispred;
        redirect_pc_d    = redirect_pc_q;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;
        if (resolve) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispred) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
            redirect_pc_d = taken ? bus_io.ex_target_i : bus_io.ex_pc_i + PC_INC;
        end
    end

    // Registered redirect and statistics state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            branch_cnt_q     <= 32'd0;
            mispred_cnt_q    <= 32'd0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign bus_io.redirect_valid_o = redirect_valid_q;
    assign bus_io.flush_o          = redirect_valid_q;
    assign bus_io.redirect_pc_o    = redirect_pc_q;
    assign bus_io.branch_cnt_o     = branch_cnt_q;
    assign bus_io.mispred_cnt_o    = mispred_cnt_q;
    assign bus_io.if_pred_taken_o  = bus_io.if_is_branch_i && bht_rd_taken;

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rd_idx_i    (bus_io.if_pc_i[IDX_W+1:2]),
        .rd_taken_o  (bht_rd_taken),
        .upd_en_i    (resolve),
        .upd_idx_i   (bus_io.ex_pc_i[IDX_W+1:2]),
        .upd_taken_i (taken)
    );

endmodule
